// File: rtl/hazard_forward_ctrl.sv
// Forwarding, regfile write-through and load-use stall control for the
// 5-stage RV32I pipeline, with a configurable data-memory latency.
module hazard_forward_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned RADDR_W      = 5,
  parameter int unsigned MEM_LAT      = 1,
  parameter int unsigned STORE_BYPASS = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RADDR_W-1:0] ID_read_reg1,
  input  logic [RADDR_W-1:0] ID_read_reg2,
  input  logic               ID_use_rs1,
  input  logic               ID_use_rs2,
  input  logic               ID_mem_w,
  input  logic [XLEN-1:0]    ID_rf_data1,
  input  logic [XLEN-1:0]    ID_rf_data2,
  input  logic [RADDR_W-1:0] ID_EXE_read_reg1,
  input  logic [RADDR_W-1:0] ID_EXE_read_reg2,
  input  logic [XLEN-1:0]    ID_EXE_ALU_A,
  input  logic [XLEN-1:0]    ID_EXE_ALU_B,
  input  logic [XLEN-1:0]    ID_EXE_data_out,
  input  logic               ID_EXE_mem_w,
  input  logic               ID_EXE_mem_r,
  input  logic               ID_EXE_reg_write,
  input  logic [RADDR_W-1:0] ID_EXE_written_reg,
  input  logic               EXE_MEM_reg_write,
  input  logic               EXE_MEM_mem_r,
  input  logic [RADDR_W-1:0] EXE_MEM_written_reg,
  input  logic [XLEN-1:0]    EXE_MEM_ALU_out,
  input  logic               MEM_WB_reg_write,
  input  logic [RADDR_W-1:0] MEM_WB_written_reg,
  input  logic [XLEN-1:0]    WB_wt_data,
  output logic [XLEN-1:0]    ID_data1,
  output logic [XLEN-1:0]    ID_data2,
  output logic [XLEN-1:0]    forwarding_ALU_A,
  output logic [XLEN-1:0]    forwarding_ALU_B,
  output logic [XLEN-1:0]    forwarding_data_out,
  output logic               stall,
  output logic               flush_ID_EXE,
  output logic [CNT_W-1:0]   stall_cycles
);

  localparam int unsigned CNT_RAW = $clog2(MEM_LAT + 1);
  localparam int unsigned SEQ_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam bit          MULTI   = (MEM_LAT > 1);
  localparam bit          ST_EXEMPT = (STORE_BYPASS == 1) && (MEM_LAT == 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_STALL = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SEQ_W-1:0]   r_cnt;
  logic [SEQ_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   r_stall_cycles;

  // Producer eligibility for EXE-stage forwarding
  logic w_exm_valid;
  logic w_mwb_valid;
  logic w_exm_rs1;
  logic w_exm_rs2;
  logic w_mwb_rs1;
  logic w_mwb_rs2;
  logic [XLEN-1:0] w_rs2_fwd;
  logic            w_rs2_hit;

  // Load-use detection terms
  logic w_ld_valid;
  logic w_ld_rs1;
  logic w_ld_rs2;
  logic w_st_exempt;
  logic w_hit;

  // WB write-through terms
  logic w_wb_valid;

  // Source qualification: a loading EXE_MEM result is not yet available
  always_comb begin
    w_exm_valid = EXE_MEM_reg_write && !EXE_MEM_mem_r && (EXE_MEM_written_reg != '0);
    w_mwb_valid = MEM_WB_reg_write && (MEM_WB_written_reg != '0);
    w_exm_rs1   = w_exm_valid && (EXE_MEM_written_reg == ID_EXE_read_reg1);
    w_exm_rs2   = w_exm_valid && (EXE_MEM_written_reg == ID_EXE_read_reg2);
    w_mwb_rs1   = w_mwb_valid && (MEM_WB_written_reg == ID_EXE_read_reg1);
    w_mwb_rs2   = w_mwb_valid && (MEM_WB_written_reg == ID_EXE_read_reg2);
  end

  // Operand A forwarding: youngest producer wins
  always_comb begin
    forwarding_ALU_A = ID_EXE_ALU_A;
    if (w_exm_rs1) begin
      forwarding_ALU_A = EXE_MEM_ALU_out;
    end else if (w_mwb_rs1) begin
      forwarding_ALU_A = WB_wt_data;
    end
  end

  // rs2 forwarding, steered to store data for stores and to operand B otherwise
  always_comb begin
    w_rs2_fwd           = ID_EXE_ALU_B;
    w_rs2_hit           = 1'b0;
    forwarding_ALU_B    = ID_EXE_ALU_B;
    forwarding_data_out = ID_EXE_data_out;
    if (w_exm_rs2) begin
      w_rs2_fwd = EXE_MEM_ALU_out;
      w_rs2_hit = 1'b1;
    end else if (w_mwb_rs2) begin
      w_rs2_fwd = WB_wt_data;
      w_rs2_hit = 1'b1;
    end
    if (w_rs2_hit) begin
      if (ID_EXE_mem_w) begin
        forwarding_data_out = w_rs2_fwd;
      end else begin
        forwarding_ALU_B = w_rs2_fwd;
      end
    end
  end

  // Regfile write-through so ID sees the value being written this cycle
  always_comb begin
    w_wb_valid = MEM_WB_reg_write && (MEM_WB_written_reg != '0);
    ID_data1   = ID_rf_data1;
    ID_data2   = ID_rf_data2;
    if (w_wb_valid && (MEM_WB_written_reg == ID_read_reg1)) begin
      ID_data1 = WB_wt_data;
    end
    if (w_wb_valid && (MEM_WB_written_reg == ID_read_reg2)) begin
      ID_data2 = WB_wt_data;
    end
  end

  // Load-use hazard; a store consuming the load only as data can skip the bubble
  always_comb begin
    w_ld_valid  = ID_EXE_mem_r && ID_EXE_reg_write && (ID_EXE_written_reg != '0);
    w_ld_rs1    = ID_use_rs1 && (ID_EXE_written_reg == ID_read_reg1);
    w_ld_rs2    = ID_use_rs2 && (ID_EXE_written_reg == ID_read_reg2);
    w_st_exempt = ST_EXEMPT && ID_mem_w && w_ld_rs2 && !w_ld_rs1;
    w_hit       = w_ld_valid && (w_ld_rs1 || w_ld_rs2) && !w_st_exempt;
  end

  // Stall sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Stall sequencer next state: first stall cycle is spent in IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_hit && MULTI) begin
          w_state_nxt = S_STALL;
          w_cnt_nxt   = SEQ_W'(MEM_LAT - 1);
        end
      end
      S_STALL: begin
        w_cnt_nxt = r_cnt - SEQ_W'(1);
        if (r_cnt <= SEQ_W'(1)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Stall sequencer outputs, suppressed during reset
  always_comb begin
    stall        = 1'b0;
    flush_ID_EXE = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE:  stall = w_hit;
        S_STALL: stall = 1'b1;
        default: stall = 1'b0;
      endcase
      flush_ID_EXE = stall;
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: three instances share stimulus
// (A: MEM_LAT=1 store bypass on; B: MEM_LAT=1 store bypass off;
//  C: MEM_LAT=3 with a 4-bit stall counter).
module tb_hazard_forward_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  ID_read_reg1, ID_read_reg2;
  logic        ID_use_rs1, ID_use_rs2, ID_mem_w;
  logic [31:0] ID_rf_data1, ID_rf_data2;
  logic [4:0]  ID_EXE_read_reg1, ID_EXE_read_reg2;
  logic [31:0] ID_EXE_ALU_A, ID_EXE_ALU_B, ID_EXE_data_out;
  logic        ID_EXE_mem_w, ID_EXE_mem_r, ID_EXE_reg_write;
  logic [4:0]  ID_EXE_written_reg;
  logic        EXE_MEM_reg_write, EXE_MEM_mem_r;
  logic [4:0]  EXE_MEM_written_reg;
  logic [31:0] EXE_MEM_ALU_out;
  logic        MEM_WB_reg_write;
  logic [4:0]  MEM_WB_written_reg;
  logic [31:0] WB_wt_data;

  logic [31:0] a_d1, a_d2, a_fa, a_fb, a_fd;
  logic        a_stall, a_flush;
  logic [15:0] a_cnt;
  logic [31:0] b_d1, b_d2, b_fa, b_fb, b_fd;
  logic        b_stall, b_flush;
  logic [15:0] b_cnt;
  logic [31:0] c_d1, c_d2, c_fa, c_fb, c_fd;
  logic        c_stall, c_flush;
  logic [3:0]  c_cnt;

  int total;
  int bad;

  hazard_forward_ctrl #(.MEM_LAT(1), .STORE_BYPASS(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst),
    .ID_read_reg1(ID_read_reg1), .ID_read_reg2(ID_read_reg2),
    .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .ID_mem_w(ID_mem_w),
    .ID_rf_data1(ID_rf_data1), .ID_rf_data2(ID_rf_data2),
    .ID_EXE_read_reg1(ID_EXE_read_reg1), .ID_EXE_read_reg2(ID_EXE_read_reg2),
    .ID_EXE_ALU_A(ID_EXE_ALU_A), .ID_EXE_ALU_B(ID_EXE_ALU_B), .ID_EXE_data_out(ID_EXE_data_out),
    .ID_EXE_mem_w(ID_EXE_mem_w), .ID_EXE_mem_r(ID_EXE_mem_r), .ID_EXE_reg_write(ID_EXE_reg_write),
    .ID_EXE_written_reg(ID_EXE_written_reg),
    .EXE_MEM_reg_write(EXE_MEM_reg_write), .EXE_MEM_mem_r(EXE_MEM_mem_r),
    .EXE_MEM_written_reg(EXE_MEM_written_reg), .EXE_MEM_ALU_out(EXE_MEM_ALU_out),
    .MEM_WB_reg_write(MEM_WB_reg_write), .MEM_WB_written_reg(MEM_WB_written_reg),
    .WB_wt_data(WB_wt_data),
    .ID_data1(a_d1), .ID_data2(a_d2), .forwarding_ALU_A(a_fa), .forwarding_ALU_B(a_fb),
    .forwarding_data_out(a_fd), .stall(a_stall), .flush_ID_EXE(a_flush), .stall_cycles(a_cnt)
  );

  hazard_forward_ctrl #(.MEM_LAT(1), .STORE_BYPASS(0), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst),
    .ID_read_reg1(ID_read_reg1), .ID_read_reg2(ID_read_reg2),
    .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .ID_mem_w(ID_mem_w),
    .ID_rf_data1(ID_rf_data1), .ID_rf_data2(ID_rf_data2),
    .ID_EXE_read_reg1(ID_EXE_read_reg1), .ID_EXE_read_reg2(ID_EXE_read_reg2),
    .ID_EXE_ALU_A(ID_EXE_ALU_A), .ID_EXE_ALU_B(ID_EXE_ALU_B), .ID_EXE_data_out(ID_EXE_data_out),
    .ID_EXE_mem_w(ID_EXE_mem_w), .ID_EXE_mem_r(ID_EXE_mem_r), .ID_EXE_reg_write(ID_EXE_reg_write),
    .ID_EXE_written_reg(ID_EXE_written_reg),
    .EXE_MEM_reg_write(EXE_MEM_reg_write), .EXE_MEM_mem_r(EXE_MEM_mem_r),
    .EXE_MEM_written_reg(EXE_MEM_written_reg), .EXE_MEM_ALU_out(EXE_MEM_ALU_out),
    .MEM_WB_reg_write(MEM_WB_reg_write), .MEM_WB_written_reg(MEM_WB_written_reg),
    .WB_wt_data(WB_wt_data),
    .ID_data1(b_d1), .ID_data2(b_d2), .forwarding_ALU_A(b_fa), .forwarding_ALU_B(b_fb),
    .forwarding_data_out(b_fd), .stall(b_stall), .flush_ID_EXE(b_flush), .stall_cycles(b_cnt)
  );

  hazard_forward_ctrl #(.MEM_LAT(3), .STORE_BYPASS(1), .CNT_W(4)) u_c (
    .clk(clk), .rst(rst),
    .ID_read_reg1(ID_read_reg1), .ID_read_reg2(ID_read_reg2),
    .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .ID_mem_w(ID_mem_w),
    .ID_rf_data1(ID_rf_data1), .ID_rf_data2(ID_rf_data2),
    .ID_EXE_read_reg1(ID_EXE_read_reg1), .ID_EXE_read_reg2(ID_EXE_read_reg2),
    .ID_EXE_ALU_A(ID_EXE_ALU_A), .ID_EXE_ALU_B(ID_EXE_ALU_B), .ID_EXE_data_out(ID_EXE_data_out),
    .ID_EXE_mem_w(ID_EXE_mem_w), .ID_EXE_mem_r(ID_EXE_mem_r), .ID_EXE_reg_write(ID_EXE_reg_write),
    .ID_EXE_written_reg(ID_EXE_written_reg),
    .EXE_MEM_reg_write(EXE_MEM_reg_write), .EXE_MEM_mem_r(EXE_MEM_mem_r),
    .EXE_MEM_written_reg(EXE_MEM_written_reg), .EXE_MEM_ALU_out(EXE_MEM_ALU_out),
    .MEM_WB_reg_write(MEM_WB_reg_write), .MEM_WB_written_reg(MEM_WB_written_reg),
    .WB_wt_data(WB_wt_data),
    .ID_data1(c_d1), .ID_data2(c_d2), .forwarding_ALU_A(c_fa), .forwarding_ALU_B(c_fb),
    .forwarding_data_out(c_fd), .stall(c_stall), .flush_ID_EXE(c_flush), .stall_cycles(c_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and land just after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ID_read_reg1 = '0; ID_read_reg2 = '0; ID_use_rs1 = 0; ID_use_rs2 = 0; ID_mem_w = 0;
    ID_rf_data1 = '0; ID_rf_data2 = '0;
    ID_EXE_read_reg1 = '0; ID_EXE_read_reg2 = '0;
    ID_EXE_ALU_A = '0; ID_EXE_ALU_B = '0; ID_EXE_data_out = '0;
    ID_EXE_mem_w = 0; ID_EXE_mem_r = 0; ID_EXE_reg_write = 0; ID_EXE_written_reg = '0;
    EXE_MEM_reg_write = 0; EXE_MEM_mem_r = 0; EXE_MEM_written_reg = '0; EXE_MEM_ALU_out = '0;
    MEM_WB_reg_write = 0; MEM_WB_written_reg = '0; WB_wt_data = '0;
  endtask

  // Load into x3 sitting in EXE
  task automatic drive_load_x3();
    ID_EXE_mem_r = 1; ID_EXE_reg_write = 1; ID_EXE_written_reg = 5'd3;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    step(); step();
    rst = 0;
    #1;
    total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL reset_stall_a got=%0d exp=0", a_stall); end
    total++; if (a_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt_a got=%0d exp=0", a_cnt); end
    total++; if (c_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt_c got=%0d exp=0", c_cnt); end
  endtask

  task automatic test_fwd_priority();
    clear_inputs();
    EXE_MEM_reg_write = 1; EXE_MEM_written_reg = 5'd5; EXE_MEM_ALU_out = 32'h11;
    MEM_WB_reg_write = 1; MEM_WB_written_reg = 5'd5; WB_wt_data = 32'h22;
    ID_EXE_read_reg1 = 5'd5; ID_EXE_ALU_A = 32'h99;
    #1;
    total++; if (a_fa !== 32'h11) begin bad++; $display("FAIL fwd_exm got=%0h exp=11", a_fa); end
    EXE_MEM_reg_write = 0; #1;
    total++; if (a_fa !== 32'h22) begin bad++; $display("FAIL fwd_mwb got=%0h exp=22", a_fa); end
    EXE_MEM_reg_write = 1; EXE_MEM_mem_r = 1; #1;
    total++; if (a_fa !== 32'h22) begin bad++; $display("FAIL fwd_exm_load got=%0h exp=22", a_fa); end
    MEM_WB_written_reg = 5'd6; EXE_MEM_mem_r = 0; EXE_MEM_written_reg = 5'd6; #1;
    total++; if (a_fa !== 32'h99) begin bad++; $display("FAIL fwd_none got=%0h exp=99", a_fa); end
  endtask

  task automatic test_store_data();
    clear_inputs();
    ID_EXE_mem_w = 1; ID_EXE_read_reg2 = 5'd7; ID_EXE_ALU_B = 32'h1234; ID_EXE_data_out = 32'h5555;
    MEM_WB_reg_write = 1; MEM_WB_written_reg = 5'd7; WB_wt_data = 32'hAB;
    #1;
    total++; if (a_fd !== 32'hAB) begin bad++; $display("FAIL st_data got=%0h exp=ab", a_fd); end
    total++; if (a_fb !== 32'h1234) begin bad++; $display("FAIL st_aluB got=%0h exp=1234", a_fb); end
    MEM_WB_written_reg = 5'd0; ID_EXE_read_reg2 = 5'd0; #1;
    total++; if (a_fd !== 32'h5555) begin bad++; $display("FAIL st_x0 got=%0h exp=5555", a_fd); end
    ID_EXE_mem_w = 0; MEM_WB_written_reg = 5'd7; ID_EXE_read_reg2 = 5'd7; #1;
    total++; if (a_fb !== 32'hAB) begin bad++; $display("FAIL aluB_fwd got=%0h exp=ab", a_fb); end
    total++; if (a_fd !== 32'h5555) begin bad++; $display("FAIL aluB_keepdata got=%0h exp=5555", a_fd); end
  endtask

  task automatic test_wb_bypass();
    clear_inputs();
    MEM_WB_reg_write = 1; MEM_WB_written_reg = 5'd9; WB_wt_data = 32'h5A;
    ID_read_reg1 = 5'd9; ID_rf_data1 = 32'h0; ID_read_reg2 = 5'd3; ID_rf_data2 = 32'h77;
    #1;
    total++; if (a_d1 !== 32'h5A) begin bad++; $display("FAIL wb_byp1 got=%0h exp=5a", a_d1); end
    total++; if (a_d2 !== 32'h77) begin bad++; $display("FAIL wb_pass2 got=%0h exp=77", a_d2); end
    MEM_WB_written_reg = 5'd0; ID_read_reg1 = 5'd0; ID_rf_data1 = 32'h3; #1;
    total++; if (a_d1 !== 32'h3) begin bad++; $display("FAIL wb_x0 got=%0h exp=3", a_d1); end
  endtask

  task automatic test_load_use();
    clear_inputs();
    step();
    // load to x0 is never a hazard
    ID_EXE_mem_r = 1; ID_EXE_reg_write = 1; ID_EXE_written_reg = 5'd0;
    ID_use_rs1 = 1; ID_read_reg1 = 5'd0; #1;
    total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL lu_x0 got=%0d exp=0", a_stall); end
    drive_load_x3(); ID_read_reg1 = 5'd3; #1;
    total++; if ({a_stall, a_flush} !== 2'b11) begin bad++; $display("FAIL lu_a_c0 got=%0b exp=11", {a_stall, a_flush}); end
    total++; if (b_stall !== 1'b1) begin bad++; $display("FAIL lu_b_c0 got=%0d exp=1", b_stall); end
    total++; if ({c_stall, c_flush} !== 2'b11) begin bad++; $display("FAIL lu_c_c0 got=%0b exp=11", {c_stall, c_flush}); end
    step(); clear_inputs(); #1;
    total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL lu_a_c1 got=%0d exp=0", a_stall); end
    total++; if (a_cnt !== 16'd1) begin bad++; $display("FAIL lu_a_cnt got=%0d exp=1", a_cnt); end
    total++; if (c_stall !== 1'b1) begin bad++; $display("FAIL lu_c_c1 got=%0d exp=1", c_stall); end
    step(); #1;
    total++; if (c_stall !== 1'b1) begin bad++; $display("FAIL lu_c_c2 got=%0d exp=1", c_stall); end
    step(); #1;
    total++; if (c_stall !== 1'b0) begin bad++; $display("FAIL lu_c_c3 got=%0d exp=0", c_stall); end
    total++; if (c_cnt !== 4'd3) begin bad++; $display("FAIL lu_c_cnt got=%0d exp=3", c_cnt); end
    total++; if (b_cnt !== 16'd1) begin bad++; $display("FAIL lu_b_cnt got=%0d exp=1", b_cnt); end
  endtask

  task automatic test_store_bypass();
    clear_inputs();
    drive_load_x3();
    ID_mem_w = 1; ID_use_rs1 = 1; ID_read_reg1 = 5'd4; ID_use_rs2 = 1; ID_read_reg2 = 5'd3;
    #1;
    total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL sb_a got=%0d exp=0", a_stall); end
    total++; if (b_stall !== 1'b1) begin bad++; $display("FAIL sb_b got=%0d exp=1", b_stall); end
    total++; if (c_stall !== 1'b1) begin bad++; $display("FAIL sb_c got=%0d exp=1", c_stall); end
    ID_read_reg1 = 5'd3; #1;
    total++; if (a_stall !== 1'b1) begin bad++; $display("FAIL sb_a_rs1 got=%0d exp=1", a_stall); end
    ID_read_reg1 = 5'd4;
    step(); clear_inputs(); step(); step(); #1;
    total++; if (a_cnt !== 16'd1) begin bad++; $display("FAIL sb_a_cnt got=%0d exp=1", a_cnt); end
    total++; if (b_cnt !== 16'd2) begin bad++; $display("FAIL sb_b_cnt got=%0d exp=2", b_cnt); end
    total++; if (c_cnt !== 4'd6) begin bad++; $display("FAIL sb_c_cnt got=%0d exp=6", c_cnt); end
    total++; if (c_stall !== 1'b0) begin bad++; $display("FAIL sb_c_end got=%0d exp=0", c_stall); end
  endtask

  task automatic test_reset_mid_stall();
    clear_inputs();
    drive_load_x3(); ID_use_rs1 = 1; ID_read_reg1 = 5'd3;
    step(); clear_inputs(); #1;
    total++; if (c_stall !== 1'b1) begin bad++; $display("FAIL rms_pre got=%0d exp=1", c_stall); end
    rst = 1; #1;
    total++; if ({c_stall, c_flush} !== 2'b00) begin bad++; $display("FAIL rms_during got=%0b exp=00", {c_stall, c_flush}); end
    step(); rst = 0; #1;
    total++; if (c_stall !== 1'b0) begin bad++; $display("FAIL rms_after got=%0d exp=0", c_stall); end
    total++; if (c_cnt !== 4'd0) begin bad++; $display("FAIL rms_cnt got=%0d exp=0", c_cnt); end
    step(); #1;
    total++; if (c_stall !== 1'b0) begin bad++; $display("FAIL rms_idle got=%0d exp=0", c_stall); end
  endtask

  task automatic test_saturation();
    clear_inputs();
    drive_load_x3(); ID_use_rs1 = 1; ID_read_reg1 = 5'd3;
    #1;
    total++; if (c_stall !== 1'b1) begin bad++; $display("FAIL sat_c0 got=%0d exp=1", c_stall); end
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 14) begin
        total++; if (c_cnt !== 4'd14) begin bad++; $display("FAIL sat_c14 got=%0d exp=14", c_cnt); end
      end
      if (k == 7) begin
        total++; if (c_stall !== 1'b1) begin bad++; $display("FAIL sat_hold got=%0d exp=1", c_stall); end
      end
    end
    total++; if (c_cnt !== 4'd15) begin bad++; $display("FAIL sat_c got=%0d exp=15", c_cnt); end
    total++; if (a_cnt !== 16'd20) begin bad++; $display("FAIL sat_a got=%0d exp=20", a_cnt); end
    clear_inputs();
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1;
    clear_inputs();
    test_reset();
    test_fwd_priority();
    test_store_data();
    test_wb_bypass();
    test_load_use();
    test_store_bypass();
    test_reset_mid_stall();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
